// File: rtl/adder_pkg.sv
// Shared definitions for the chunked sequential adder.
//   state_e    : operation FSM states (idle / busy / done)
//   calc_nch   : number of compute cycles per operation (WIDTH / CHUNK)
//   cnt_width  : chunk counter width, clog2(nch) clamped to at least 1 bit
package adder_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic int unsigned calc_nch(input int unsigned width, input int unsigned chunk);
        return width / chunk;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder built from half-adder cell pairs.
//   a_i, b_i : chunk operands
//   cin_i    : carry into bit 0
//   sum_o    : chunk sum
//   cout_o   : carry out of the MSB
//   cmsb_o   : carry into the MSB (XOR with cout_o gives signed overflow)
module chunk_adder #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o,
    output logic             cmsb_o
);

    logic [CHUNK:0] carry;

    assign carry[0] = cin_i;

    // Each bit is two half-adder cells: operands first, then the incoming carry.
    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        logic ha0_s;
        logic ha0_c;
        logic ha1_c;

        assign ha0_s        = a_i[i] ^ b_i[i];
        assign ha0_c        = a_i[i] & b_i[i];
        assign sum_o[i]     = ha0_s ^ carry[i];
        assign ha1_c        = ha0_s & carry[i];
        assign carry[i+1]   = ha0_c | ha1_c;
    end

    assign cout_o = carry[CHUNK];
    assign cmsb_o = carry[CHUNK-1];

endmodule

// File: rtl/half_adder_seq.sv
// Sequential WIDTH-bit adder that processes CHUNK bits per cycle.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b, cin captured in idle)
//   out_valid/out_ready : result handshake
//   sum, cout, ovf      : a+b+cin mod 2^WIDTH, unsigned carry-out, signed overflow
// Result registers only change on the final compute edge and hold otherwise.
module half_adder_seq
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NCH = calc_nch(WIDTH, CHUNK);
    localparam int unsigned CW  = cnt_width(NCH);

    if ((WIDTH == 0) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
        $error("half_adder_seq: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] a_ch;
    logic [CHUNK-1:0] b_ch;
    logic [CHUNK-1:0] ch_sum;
    logic             ch_cout;
    logic             ch_cmsb;
    logic [WIDTH-1:0] acc_merged;
    logic             last_chunk;

    assign last_chunk = (cnt_q == CW'(NCH - 1));

    // Select the current chunk of each operand and splice the new partial sum
    // into the accumulator image; constant indices keep the muxes width-clean.
    always_comb begin
        a_ch       = '0;
        b_ch       = '0;
        acc_merged = acc_q;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (cnt_q == CW'(k)) begin
                a_ch                           = a_q[k*CHUNK +: CHUNK];
                b_ch                           = b_q[k*CHUNK +: CHUNK];
                acc_merged[k*CHUNK +: CHUNK]   = ch_sum;
            end
        end
    end

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a_i    (a_ch),
        .b_i    (b_ch),
        .cin_i  (carry_q),
        .sum_o  (ch_sum),
        .cout_o (ch_cout),
        .cmsb_o (ch_cmsb)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                acc_d   = acc_merged;
                carry_d = ch_cout;
                if (last_chunk) begin
                    cnt_d   = '0;
                    sum_d   = acc_merged;
                    cout_d  = ch_cout;
                    ovf_d   = ch_cmsb ^ ch_cout;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
